// File: rtl/instr_mem_pkg.sv
// Shared state type and byte-address helpers for instr_mem_sync.
// Statistics outputs are compiled in when INSTR_MEM_STATS_EN is defined.
package instr_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned BYTE_OFF_W = $clog2(DEF_DATA_W / 8);

    function automatic logic [63:0] addr_to_idx(
        input logic [63:0] addr,
        input int unsigned off_w = BYTE_OFF_W
    );
        return addr >> off_w;
    endfunction

    // Misaligned or beyond the array; high bits are never wrapped.
    function automatic logic addr_err(
        input logic [63:0] addr,
        input int unsigned depth,
        input int unsigned off_w = BYTE_OFF_W
    );
        logic [63:0] mask;
        mask = (64'd1 << off_w) - 64'd1;
        return (|(addr & mask))
            || (addr_to_idx(addr, off_w) >= 64'(depth));
    endfunction

endpackage

// File: rtl/instr_mem_sync_if.sv
// Fetch request/response bundle with valid/ready on both sides.
interface instr_mem_sync_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic              resp_ready;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_W RAM, one write port and one synchronous read port.
module instr_mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[widx] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[ridx];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/instr_mem_sync.sv
// Clocked instruction memory: clear sequencer, load port, 1-cycle fetch.
// Define INSTR_MEM_STATS_EN to add fetch_cnt/err_cnt outputs.
module instr_mem_sync
    import instr_mem_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 64,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       IDX_W    = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] CLR_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
`ifdef INSTR_MEM_STATS_EN
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       err_cnt,
`endif
    output logic              init_done,
    instr_mem_sync_if.slave   bus
);
    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;

    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       addr_ext;
    logic [IDX_W-1:0]  req_idx;
    logic              req_err;
    logic              req_ready;
    logic              accept;

    logic              we;
    logic [IDX_W-1:0]  widx;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    assign req_addr = bus.req_addr;
    assign addr_ext = 64'(req_addr);
    assign req_idx  = IDX_W'(addr_to_idx(addr_ext, OFF_W));
    assign req_err  = addr_err(addr_ext, DEPTH, OFF_W);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        we        = 1'b0;
        widx      = ld_idx;
        wdata     = ld_data;
        unique case (state_q)
            CLEAR: begin
                we    = 1'b1;
                widx  = clr_cnt_q;
                wdata = CLR_WORD;
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d   = READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + IDX_W'(1);
                end
            end
            READY: begin
                we = ld_en;
            end
        endcase
    end

    // Loads win over fetches, so a read never races a write.
    assign req_ready = (state_q == READY) && !ld_en
                    && (!resp_valid_q || bus.resp_ready);
    assign accept    = bus.req_valid && req_ready;

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_err_d   = req_err;
        end else if (bus.resp_ready) begin
            resp_valid_d = 1'b0;
            resp_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    instr_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (we),
        .widx   (widx),
        .wdata  (wdata),
        .re     (accept),
        .ridx   (req_idx),
        .rdata  (rdata)
    );

    assign ld_ready       = (state_q == READY);
    assign init_done      = (state_q == READY);
    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_data  = (resp_valid_q && !resp_err_q) ? rdata : '0;

`ifdef INSTR_MEM_STATS_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (accept && fetch_cnt_q != 16'hFFFF) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end
        if (accept && req_err && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif
endmodule

// File: tb/tb_instr_mem_sync.sv
// Scoreboard bench for instr_mem_sync (DEPTH=64, 32-bit words).
module tb_instr_mem_sync;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic [5:0]  ld_idx;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        init_done;
`ifdef INSTR_MEM_STATS_EN
    logic [15:0] fetch_cnt;
    logic [15:0] err_cnt;
`endif

    instr_mem_sync_if #(.DATA_W(32), .ADDR_W(32)) bus();

    instr_mem_sync #(
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .ADDR_W   (32),
        .IDX_W    (6),
        .CLR_WORD (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_en     (ld_en),
        .ld_idx    (ld_idx),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
`ifdef INSTR_MEM_STATS_EN
        .fetch_cnt (fetch_cnt),
        .err_cnt   (err_cnt),
`endif
        .init_done (init_done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [DEPTH];
    logic [32:0] sb_q [$];
    logic [32:0] sb_e;
    logic [31:0] prog [11] = '{
        32'h05912000, 32'h00002083, 32'h00402103, 32'h002081B3,
        32'h40208233, 32'h0020F2B3, 32'h0020E333, 32'h0020A3B3,
        32'h00302423, 32'hFE000EE3, 32'h00000013
    };

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model_rd(input logic [31:0] a);
        if (a[1:0] != 2'b00 || a >= 32'd256) return {1'b1, 32'h0};
        return {1'b0, model[a[7:2]]};
    endfunction

    // Pop on response handshake first, then push this edge's accept.
    always @(posedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (bus.resp_valid && bus.resp_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected", 1, 0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_data", bus.resp_data, sb_e[31:0]);
                    check("sb_err", bus.resp_err, sb_e[32]);
                end
            end
            if (bus.req_valid && bus.req_ready)
                sb_q.push_back(model_rd(bus.req_addr));
        end
    end

    task automatic do_reset(input int abort_at);
        int t = 0;
        @(negedge clk);
        rst = 1'b1;
        ld_en = 1'b0;
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_data", bus.resp_data, 0);
        check("rst_init_done", init_done, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_req_ready", bus.req_ready, 0);
`ifdef INSTR_MEM_STATS_EN
        check("rst_fetch_cnt", fetch_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
`endif
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        if (abort_at > 0) begin
            repeat (abort_at) @(negedge clk);
            check("mid_init_done", init_done, 0);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        while (!init_done && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("clr_len", t, 64);
    endtask

    task automatic issue(input logic [31:0] a);
        int t = 0;
        bus.req_valid = 1'b1;
        bus.req_addr = a;
        #1;
        while (!bus.req_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 50) check("req_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        ld_en = 1'b1;
        ld_idx = 6'(idx);
        ld_data = d;
        model[idx] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ld_en = 1'b0;
        ld_idx = '0;
        ld_data = '0;
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.resp_ready = 1'b1;

        do_reset(0);
        for (int i = 0; i < 64; i++) begin
            issue(32'(i * 4));
            check("clr_word", bus.resp_data, 0);
        end
        idle(3);

        for (int i = 0; i < 11; i++) load(i, prog[i]);
        for (int i = 0; i < 11; i++) begin
            issue(32'(i * 4));
            check("b2b_valid", bus.resp_valid, 1);
            check("b2b_data", bus.resp_data, prog[i]);
        end
        idle(3);

        issue(32'd8);
        bus.resp_ready = 1'b0;
        bus.req_addr = 32'd12;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_req_ready", bus.req_ready, 0);
            check("bp_valid", bus.resp_valid, 1);
            check("bp_data", bus.resp_data, prog[2]);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        #1;
        check("bp_release", bus.req_ready, 1);
        @(negedge clk);
        check("bp_next", bus.resp_data, prog[3]);
        idle(3);

        do_reset(0);
        issue(32'h2);
        check("mis_err", bus.resp_err, 1);
        check("mis_data", bus.resp_data, 0);
        issue(32'd256);
        check("oor_err", bus.resp_err, 1);
        check("oor_data", bus.resp_data, 0);
        issue(32'd252);
        check("last_err", bus.resp_err, 0);
        idle(3);
`ifdef INSTR_MEM_STATS_EN
        check("fetch_cnt", fetch_cnt, 3);
        check("err_cnt", err_cnt, 2);
`endif

        ld_en = 1'b1;
        ld_idx = 6'd7;
        ld_data = 32'hCAFE0013;
        model[7] = 32'hCAFE0013;
        bus.req_valid = 1'b1;
        bus.req_addr = 32'd28;
        #1;
        check("prio_req_ready", bus.req_ready, 0);
        @(negedge clk);
        ld_en = 1'b0;
        #1;
        check("prio_after", bus.req_ready, 1);
        @(negedge clk);
        check("raw_valid", bus.resp_valid, 1);
        check("raw_data", bus.resp_data, 32'hCAFE0013);
        idle(3);

        do_reset(20);
        issue(32'd28);
        check("post_rst_data", bus.resp_data, 0);
        idle(3);
        check("sb_drain", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
